// File: rtl/mem_io_bridge.sv
// mem_io_bridge
//   Decodes the cpu byte bus onto RAM, the UART tx/rx byte streams and a
//   free-running cycle counter. Reads return one cycle after the request;
//   UART bytes are queued in a small tx FIFO whose near-full flag lets the
//   cpu throttle early enough that stores already in flight still fit.
//
// Ports
//   clk_in, rst_in              clock, synchronous active-high reset
//   rdy_in                      cpu-side enable; low freezes cpu-side state
//   cpu_a/cpu_wdata/cpu_wr      cpu request (address, write data, write strobe)
//   cpu_rdata                   read data, valid the cycle after the request
//   io_buffer_full              tx FIFO near-full, to cpu
//   ram_a/ram_wdata/ram_we      RAM request; ram_rdata returns one cycle later
//   tx_valid/tx_data/tx_ready   tx byte stream out of the FIFO head
//   rx_valid/rx_data/rx_pop     rx byte stream, rx_pop consumes one byte
//   tx_overflow                 sticky: a push was dropped on a full FIFO
//   prog_done                   sticky: stop byte sent and FIFO drained
//
// Stop state machine
//   state       | meaning
//   ST_RUN      | IO writes push bytes; a 0x30004 write queues the stop byte
//   ST_STOPPING | stop byte queued; IO writes ignored while the FIFO drains
//   ST_DONE     | drained; prog_done held until reset, reads still served
module mem_io_bridge #(
  parameter int TX_DEPTH    = 8,
  parameter int FULL_MARGIN = 2,
  parameter int RAM_AW      = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_wdata,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_rdata,
  output logic              io_buffer_full,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_pop,
  output logic              tx_overflow,
  output logic              prog_done
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_DEPTH);
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_W'(TX_DEPTH - FULL_MARGIN);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_STOPPING = 2'd1,
    ST_DONE     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             io_sel, io_rd, io_wr;
  logic [2:0]       io_lo;
  logic             io_sel_q, io_sel_d;
  logic [7:0]       io_rdata_q, io_rdata_d, rd_val;
  logic [31:0]      cyc_q, cyc_d, snap_q, snap_d;
  logic [7:0]       fifo_q [TX_DEPTH];
  logic [7:0]       fifo_d [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             buf_full_q, buf_full_d;
  logic             overflow_q, overflow_d;
  logic             push_req, push_ok, pop, fifo_full;
  logic [7:0]       push_data;
  logic             unused_hi;

  // Only bits [17:16] select the IO page; upper address bits are don't-care.
  assign unused_hi = ^cpu_a[31:18];

  assign io_sel = (cpu_a[17:16] == 2'b11);
  assign io_lo  = cpu_a[2:0];
  assign io_rd  = rdy_in & ~cpu_wr & io_sel;
  assign io_wr  = rdy_in & cpu_wr & io_sel;

  assign ram_a     = cpu_a[RAM_AW-1:0];
  assign ram_wdata = cpu_wdata;
  assign ram_we    = rdy_in & cpu_wr & ~io_sel;

  assign cpu_rdata = io_sel_q ? io_rdata_q : ram_rdata;
  assign rx_pop    = io_rd & (io_lo == 3'd0) & rx_valid;

  assign tx_valid  = (count_q != '0);
  assign tx_data   = fifo_q[rd_ptr_q];
  assign pop       = tx_valid & tx_ready;
  assign fifo_full = (count_q == CNT_FULL);

  assign io_buffer_full = buf_full_q;
  assign tx_overflow    = overflow_q;
  assign prog_done      = (state_q == ST_DONE);

  always_comb begin
    rd_val = 8'h00;
    case (io_lo)
      3'd0:    rd_val = rx_valid ? rx_data : 8'h00;
      3'd4:    rd_val = cyc_q[7:0];
      3'd5:    rd_val = snap_q[15:8];
      3'd6:    rd_val = snap_q[23:16];
      3'd7:    rd_val = snap_q[31:24];
      default: rd_val = 8'h00;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    io_sel_d   = io_sel_q;
    io_rdata_d = io_rdata_q;
    cyc_d      = cyc_q;
    snap_d     = snap_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    push_req   = 1'b0;
    push_data  = 8'h00;
    push_ok    = 1'b0;
    // Registered from the current count, so the flag trails the count by one cycle.
    buf_full_d = (count_q >= CNT_NEAR);

    if (rdy_in) begin
      cyc_d      = cyc_q + 32'd1;
      io_sel_d   = io_sel;
      io_rdata_d = rd_val;
      // The low-byte read freezes a copy so the upper bytes read back coherently.
      if (io_rd && io_lo == 3'd4) snap_d = cyc_q;
    end

    case (state_q)
      ST_RUN: begin
        if (io_wr) begin
          if (io_lo == 3'd0 && cpu_wdata != 8'h00) begin
            push_req  = 1'b1;
            push_data = cpu_wdata;
          end else if (io_lo == 3'd4) begin
            push_req = 1'b1;
            state_d  = ST_STOPPING;
          end
        end
      end
      ST_STOPPING: begin
        if (count_q == '0 && !pop) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_RUN;
    endcase

    // A push into a full FIFO still fits if the head leaves in the same cycle.
    push_ok = push_req && (!fifo_full || pop);
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= ST_RUN;
      io_sel_q   <= 1'b0;
      io_rdata_q <= 8'h00;
      cyc_q      <= 32'd0;
      snap_q     <= 32'd0;
      for (int i = 0; i < TX_DEPTH; i++) fifo_q[i] <= 8'h00;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      buf_full_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      io_sel_q   <= io_sel_d;
      io_rdata_q <= io_rdata_d;
      cyc_q      <= cyc_d;
      snap_q     <= snap_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      buf_full_q <= buf_full_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_mem_io_bridge.sv
module tb_mem_io_bridge;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic [31:0] cpu_a = 32'h0;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_wr = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        io_buffer_full;
  logic [16:0] ram_a;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata = 8'h00;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_pop;
  logic        tx_overflow;
  logic        prog_done;

  int total = 0;
  int bad = 0;

  logic [7:0] ram_m [int];
  logic [7:0] tx_got [$];

  mem_io_bridge dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .cpu_a(cpu_a), .cpu_wdata(cpu_wdata), .cpu_wr(cpu_wr),
    .cpu_rdata(cpu_rdata), .io_buffer_full(io_buffer_full),
    .ram_a(ram_a), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_pop(rx_pop),
    .tx_overflow(tx_overflow), .prog_done(prog_done)
  );

  always #5 clk_in = ~clk_in;

  // External RAM stub with one-cycle read latency.
  always @(posedge clk_in) begin
    if (ram_we) ram_m[int'(ram_a)] = ram_wdata;
    ram_rdata <= ram_m.exists(int'(ram_a)) ? ram_m[int'(ram_a)] : 8'h00;
  end

  // UART sink: every handshake is one transmitted byte.
  always @(negedge clk_in) begin
    if (!rst_in && tx_valid && tx_ready) tx_got.push_back(tx_data);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_idle();
    cpu_wr = 1'b0; cpu_a = 32'h0; cpu_wdata = 8'h00;
    #1;
  endtask

  task automatic drive_write(input logic [31:0] a, input logic [7:0] d);
    cpu_wr = 1'b1; cpu_a = a; cpu_wdata = d;
    #1;
  endtask

  task automatic drive_read(input logic [31:0] a);
    cpu_wr = 1'b0; cpu_a = a; cpu_wdata = 8'h00;
    #1;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0;
    drive_idle();
    repeat (3) tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%0h exp=0", tx_valid); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
    total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0h exp=0", io_buffer_full); end
    total++; if ({tx_overflow, prog_done} !== 2'b00) begin bad++; $display("FAIL reset_sticky got=%0b exp=00", {tx_overflow, prog_done}); end
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%0h exp=0", cpu_rdata); end
    total++; if ({ram_we, rx_pop} !== 2'b00) begin bad++; $display("FAIL reset_strobes got=%0b exp=00", {ram_we, rx_pop}); end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    logic [7:0] exp_m [int];
    logic [31:0] a;
    logic [7:0] d;
    drive_write(32'h0000_0100, 8'hA5);
    total++; if ({ram_we, ram_a, ram_wdata} !== {1'b1, 17'h00100, 8'hA5}) begin bad++; $display("FAIL ram_write_req got we=%0b a=%0h d=%0h exp we=1 a=100 d=a5", ram_we, ram_a, ram_wdata); end
    tick();
    drive_read(32'h0000_0100);
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL ram_we_read got=%0b exp=0", ram_we); end
    tick();
    total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL ram_readback got=%0h exp=a5", cpu_rdata); end
    rdy_in = 1'b0;
    drive_write(32'h0000_0200, 8'h11);
    total++; if (ram_we !== 1'b0) begin bad++; $display("FAIL ram_we_frozen got=%0b exp=0", ram_we); end
    tick();
    rdy_in = 1'b1;
    drive_read(32'h0000_0200);
    tick();
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL ram_frozen_write_read got=%0h exp=0", cpu_rdata); end
    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(32'h0_1000, 32'h1_FFFF) | ($urandom & 32'hFFFC_0000);
      d = 8'($urandom);
      exp_m[int'(a[16:0])] = d;
      drive_write(a, d);
      tick();
    end
    foreach (exp_m[k]) begin
      drive_read(32'(k) | ($urandom & 32'hFFFC_0000));
      tick();
      total++; if (cpu_rdata !== exp_m[k]) begin bad++; $display("FAIL ram_random a=%0h got=%0h exp=%0h", k, cpu_rdata, exp_m[k]); end
    end
    drive_idle();
  endtask

  task automatic test_tx_basic();
    tx_got.delete();
    tx_ready = 1'b1;
    drive_write(32'h3_0000, 8'h48); tick();
    drive_write(32'h3_0000, 8'h69); tick();
    drive_write(32'h3_0000, 8'h00); tick();
    drive_idle();
    repeat (8) tick();
    total++; if (tx_got.size() !== 2) begin bad++; $display("FAIL tx_basic_count got=%0d exp=2", tx_got.size()); end
    else begin
      total++; if ({tx_got[0], tx_got[1]} !== 16'h4869) begin bad++; $display("FAIL tx_basic_bytes got=%0h%0h exp=4869", tx_got[0], tx_got[1]); end
    end
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_basic_empty got=%0b exp=0", tx_valid); end
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q [$];
    logic [7:0] d;
    tx_got.delete();
    for (int i = 0; i < 120; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if (!io_buffer_full && $urandom_range(0, 2) != 0) begin
        d = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
        if (d != 8'h00) exp_q.push_back(d);
        drive_write(32'h3_0000, d);
      end else begin
        drive_idle();
      end
      tick();
    end
    drive_idle();
    tx_ready = 1'b1;
    repeat (14) tick();
    total++; if (tx_got.size() !== exp_q.size()) begin bad++; $display("FAIL rand_stream_count got=%0d exp=%0d", tx_got.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tx_got[i] !== exp_q[i]) begin bad++; $display("FAIL rand_stream_byte idx=%0d got=%0h exp=%0h", i, tx_got[i], exp_q[i]); end
      end
    end
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL rand_stream_overflow got=%0b exp=0", tx_overflow); end
  endtask

  task automatic test_push_pop_full();
    logic [7:0] exp_q [$];
    tx_got.delete();
    tx_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive_write(32'h3_0000, 8'hA0 + 8'(k)); exp_q.push_back(8'hA0 + 8'(k)); tick();
    end
    tx_ready = 1'b1;
    drive_write(32'h3_0000, 8'hEE); exp_q.push_back(8'hEE); tick();
    tx_ready = 1'b0;
    drive_idle(); tick();
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL pushpop_full_overflow got=%0b exp=0", tx_overflow); end
    total++; if (io_buffer_full !== 1'b1) begin bad++; $display("FAIL pushpop_full_flag got=%0b exp=1", io_buffer_full); end
    tx_ready = 1'b1;
    repeat (14) tick();
    total++; if (tx_got.size() !== exp_q.size()) begin bad++; $display("FAIL pushpop_count got=%0d exp=%0d", tx_got.size(), exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++; if (tx_got[i] !== exp_q[i]) begin bad++; $display("FAIL pushpop_byte idx=%0d got=%0h exp=%0h", i, tx_got[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_full();
    int cnt;
    tx_got.delete();
    tx_ready = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 7; k++) begin
      drive_write(32'h3_0000, 8'(k)); tick(); cnt++;
      if (k == 6) begin
        total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL full_lag got=%0b exp=0", io_buffer_full); end
      end
      drive_idle(); tick();
      total++; if (io_buffer_full !== ((8 - cnt) <= 2)) begin bad++; $display("FAIL full_flag writes=%0d got=%0b exp=%0b", k, io_buffer_full, ((8 - cnt) <= 2)); end
    end
    drive_write(32'h3_0000, 8'd8); tick();
    drive_idle();
    total++; if (tx_overflow !== 1'b0) begin bad++; $display("FAIL full_8th_overflow got=%0b exp=0", tx_overflow); end
    drive_write(32'h3_0000, 8'd9); tick();
    drive_idle();
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL full_9th_overflow got=%0b exp=1", tx_overflow); end
    tx_ready = 1'b1;
    repeat (14) tick();
    total++; if (tx_got.size() !== 8) begin bad++; $display("FAIL full_drain_count got=%0d exp=8", tx_got.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        total++; if (tx_got[i] !== 8'(i + 1)) begin bad++; $display("FAIL full_drain_byte idx=%0d got=%0h exp=%0h", i, tx_got[i], i + 1); end
      end
    end
    total++; if (io_buffer_full !== 1'b0) begin bad++; $display("FAIL full_release got=%0b exp=0", io_buffer_full); end
    total++; if (tx_overflow !== 1'b1) begin bad++; $display("FAIL full_overflow_sticky got=%0b exp=1", tx_overflow); end
  endtask

  task automatic test_cycle_counter();
    logic [31:0] exp_cyc;
    logic [31:0] snap;
    int n;
    tx_ready = 1'b0;
    drive_idle();
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    exp_cyc = 0;
    n = 1000 + $urandom_range(0, 500);
    repeat (n) begin tick(); exp_cyc++; end
    drive_read(32'h3_0004); snap = exp_cyc; tick(); exp_cyc++;
    total++; if (cpu_rdata !== snap[7:0]) begin bad++; $display("FAIL cyc_lo got=%0h exp=%0h", cpu_rdata, snap[7:0]); end
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx_valid = 1'b1; rx_data = 8'h5C;
      if (i < 2)       drive_write(32'h3_0000, 8'h55);
      else if (i == 2) drive_write(32'h0000_0300, 8'h66);
      else             drive_read(32'h3_0000);
      total++; if ({ram_we, rx_pop} !== 2'b00) begin bad++; $display("FAIL freeze_strobes cyc=%0d got=%0b exp=00", i, {ram_we, rx_pop}); end
      tick();
      total++; if ({tx_valid, cpu_rdata} !== {1'b0, snap[7:0]}) begin bad++; $display("FAIL freeze_hold cyc=%0d got valid=%0b rdata=%0h exp valid=0 rdata=%0h", i, tx_valid, cpu_rdata, snap[7:0]); end
    end
    rdy_in = 1'b1; rx_valid = 1'b0;
    drive_read(32'h3_0005); tick(); exp_cyc++;
    total++; if (cpu_rdata !== snap[15:8]) begin bad++; $display("FAIL snap_b1 got=%0h exp=%0h", cpu_rdata, snap[15:8]); end
    drive_read(32'h3_0006); tick(); exp_cyc++;
    total++; if (cpu_rdata !== snap[23:16]) begin bad++; $display("FAIL snap_b2 got=%0h exp=%0h", cpu_rdata, snap[23:16]); end
    drive_read(32'h3_0007); tick(); exp_cyc++;
    total++; if (cpu_rdata !== snap[31:24]) begin bad++; $display("FAIL snap_b3 got=%0h exp=%0h", cpu_rdata, snap[31:24]); end
    drive_read(32'h3_0001); tick(); exp_cyc++;
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL io_other_addr got=%0h exp=0", cpu_rdata); end
    drive_read(32'h3_0004); snap = exp_cyc; tick(); exp_cyc++;
    total++; if (cpu_rdata !== snap[7:0]) begin bad++; $display("FAIL cyc_after_freeze got=%0h exp=%0h", cpu_rdata, snap[7:0]); end
    drive_read(32'h3_0005); tick();
    total++; if (cpu_rdata !== snap[15:8]) begin bad++; $display("FAIL snap2_b1 got=%0h exp=%0h", cpu_rdata, snap[15:8]); end
    drive_idle();
  endtask

  task automatic test_rx();
    logic v;
    logic [7:0] d;
    rx_valid = 1'b1; rx_data = 8'h37;
    drive_read(32'h3_0000);
    total++; if (rx_pop !== 1'b1) begin bad++; $display("FAIL rx_pop_pulse got=%0b exp=1", rx_pop); end
    tick();
    total++; if (cpu_rdata !== 8'h37) begin bad++; $display("FAIL rx_data_return got=%0h exp=37", cpu_rdata); end
    drive_idle();
    total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_single got=%0b exp=0", rx_pop); end
    drive_read(32'h3_0004);
    total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_wrong_addr got=%0b exp=0", rx_pop); end
    tick();
    rx_valid = 1'b0;
    drive_read(32'h3_0000);
    total++; if (rx_pop !== 1'b0) begin bad++; $display("FAIL rx_pop_empty got=%0b exp=0", rx_pop); end
    tick();
    total++; if (cpu_rdata !== 8'h00) begin bad++; $display("FAIL rx_empty_data got=%0h exp=0", cpu_rdata); end
    for (int i = 0; i < 6; i++) begin
      v = 1'($urandom_range(0, 1)); d = 8'($urandom);
      rx_valid = v; rx_data = d;
      drive_read(32'h3_0000);
      total++; if (rx_pop !== v) begin bad++; $display("FAIL rx_rand_pop got=%0b exp=%0b", rx_pop, v); end
      tick();
      total++; if (cpu_rdata !== (v ? d : 8'h00)) begin bad++; $display("FAIL rx_rand_data got=%0h exp=%0h", cpu_rdata, (v ? d : 8'h00)); end
    end
    rx_valid = 1'b0;
    drive_idle();
  endtask

  task automatic test_stop();
    logic [7:0] b [3];
    tx_got.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b[i] = 8'($urandom_range(1, 255));
      drive_write(32'h3_0000, b[i]); tick();
    end
    drive_write(32'h3_0004, 8'hFF); tick();
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL stop_not_done got=%0b exp=0", prog_done); end
    drive_write(32'h3_0000, 8'h99); tick();
    drive_idle();
    tx_ready = 1'b1;
    repeat (10) tick();
    total++; if (tx_got.size() !== 4) begin bad++; $display("FAIL stop_count got=%0d exp=4", tx_got.size()); end
    else begin
      total++; if ({tx_got[0], tx_got[1], tx_got[2], tx_got[3]} !== {b[0], b[1], b[2], 8'h00}) begin bad++; $display("FAIL stop_bytes got=%0h %0h %0h %0h exp=%0h %0h %0h 00", tx_got[0], tx_got[1], tx_got[2], tx_got[3], b[0], b[1], b[2]); end
    end
    total++; if (prog_done !== 1'b1) begin bad++; $display("FAIL stop_done got=%0b exp=1", prog_done); end
    drive_write(32'h3_0000, 8'h77); tick();
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL done_write_ignored got=%0b exp=0", tx_valid); end
    drive_read(32'h0000_0100); tick();
    total++; if (cpu_rdata !== 8'hA5) begin bad++; $display("FAIL done_read_served got=%0h exp=a5", cpu_rdata); end
    drive_idle();
    repeat (3) tick();
    total++; if (tx_got.size() !== 4 || prog_done !== 1'b1) begin bad++; $display("FAIL done_sticky got count=%0d done=%0b exp count=4 done=1", tx_got.size(), prog_done); end
  endtask

  task automatic test_reset_mid_drain();
    drive_idle();
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    total++; if (prog_done !== 1'b0) begin bad++; $display("FAIL rst_clears_done got=%0b exp=0", prog_done); end
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_write(32'h3_0000, 8'h10 + 8'(i)); tick();
    end
    drive_idle();
    rst_in = 1'b1; tick(); rst_in = 1'b0;
    total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_drain_valid got=%0b exp=0", tx_valid); end
    tx_got.delete();
    tx_ready = 1'b1;
    repeat (5) tick();
    total++; if (tx_got.size() !== 0) begin bad++; $display("FAIL rst_discard got=%0d exp=0", tx_got.size()); end
    drive_write(32'h3_0000, 8'h5A); tick();
    drive_idle();
    repeat (3) tick();
    total++; if (tx_got.size() !== 1) begin bad++; $display("FAIL rst_run_again_count got=%0d exp=1", tx_got.size()); end
    else begin
      total++; if (tx_got[0] !== 8'h5A) begin bad++; $display("FAIL rst_run_again_byte got=%0h exp=5a", tx_got[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx_basic();
    test_random_stream();
    test_push_pop_full();
    test_full();
    test_cycle_counter();
    test_rx();
    test_stop();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
